rename_map_table: RTL

//   Register alias table: maps 32 architectural registers to 8-bit physical tags.

---
 rtl/rename_map_table.sv | 107 ++++++++++
 1 files changed

// File: rtl/rename_map_table.sv
// Register alias table: 32 architectural registers -> TAG_W-bit physical tags, with checkpoint pages.
// Optional macro RMT_X0_FIXED_EN pins x0 to physical tag 0 and never renames it.
module rename_map_table #(
  parameter int ARCH_REGS = 32,
  parameter int TAG_W     = 8,
  parameter int NUM_CKPT  = 8,
  parameter int CKPT_W    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ren_valid,
  output logic                       ren_ready,
  input  logic [$clog2(ARCH_REGS)-1:0] ren_rs1,
  input  logic [$clog2(ARCH_REGS)-1:0] ren_rs2,
  input  logic [$clog2(ARCH_REGS)-1:0] ren_rd,
  input  logic                       ren_rd_we,
  input  logic                       free_valid,
  input  logic [TAG_W-1:0]           free_tag,
  output logic                       free_pop,
  output logic                       out_valid,
  output logic [TAG_W-1:0]           out_rs1_tag,
  output logic [TAG_W-1:0]           out_rs2_tag,
  output logic [TAG_W-1:0]           out_rd_tag,
  output logic [TAG_W-1:0]           out_old_tag,
  input  logic                       save_state,
  input  logic [CKPT_W-1:0]          save_page,
  input  logic                       restore_state,
  input  logic [CKPT_W-1:0]          restore_page,
  output logic [NUM_CKPT-1:0]        ckpt_valid,
  output logic                       restore_err
);

  logic [TAG_W-1:0] map_q    [ARCH_REGS];
  logic [TAG_W-1:0] map_next [ARCH_REGS];
  logic [TAG_W-1:0] ckpt_q   [NUM_CKPT][ARCH_REGS];
  logic [NUM_CKPT-1:0] ckpt_valid_q;

  logic need_tag;
  logic accept;
  logic restore_ok;
  logic [TAG_W-1:0] rs1_tag, rs2_tag, old_tag;

`ifdef RMT_X0_FIXED_EN
  assign need_tag = ren_rd_we && (ren_rd != '0);
  assign rs1_tag  = (ren_rs1 == '0) ? '0 : map_q[ren_rs1];
  assign rs2_tag  = (ren_rs2 == '0) ? '0 : map_q[ren_rs2];
`else
  assign need_tag = ren_rd_we;
  assign rs1_tag  = map_q[ren_rs1];
  assign rs2_tag  = map_q[ren_rs2];
`endif

  // Old tag is only meaningful for release when a new tag is actually allocated.
  assign old_tag    = need_tag ? map_q[ren_rd] : '0;
  assign ren_ready  = !restore_state && (free_valid || !need_tag);
  assign accept     = ren_valid && ren_ready;
  assign free_pop   = accept && need_tag;
  assign restore_ok = restore_state && ckpt_valid_q[restore_page];
  assign ckpt_valid = ckpt_valid_q;

  // Map as it stands after this cycle's rename; a same-cycle save captures this view.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments and a full default first, so no latch is inferred.
    for (int i = 0; i < ARCH_REGS; i++) map_next[i] = map_q[i];
    if (accept && need_tag) map_next[ren_rd] = free_tag;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= TAG_W'(i);
      ckpt_valid_q <= '0;
      out_valid    <= 1'b0;
      out_rs1_tag  <= '0;
      out_rs2_tag  <= '0;
      out_rd_tag   <= '0;
      out_old_tag  <= '0;
      restore_err  <= 1'b0;
    end else begin
      out_valid   <= accept;
      restore_err <= restore_state && !ckpt_valid_q[restore_page];
      if (accept) begin
        out_rs1_tag <= rs1_tag;
        out_rs2_tag <= rs2_tag;
        out_rd_tag  <= need_tag ? free_tag : '0;
        out_old_tag <= old_tag;
      end
      if (restore_state) begin
        if (restore_ok) begin
          for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= ckpt_q[restore_page][i];
          ckpt_valid_q[restore_page] <= 1'b0;
        end
      end else begin
        for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= map_next[i];
        if (save_state) ckpt_valid_q[save_page] <= 1'b1;
      end
    end
  end

  // NOTE: snapshot storage is deliberately not reset; ckpt_valid alone decides whether a page is usable.
  always_ff @(posedge clk) begin
    if (!reset && !restore_state && save_state) begin
      for (int i = 0; i < ARCH_REGS; i++) ckpt_q[save_page][i] <= map_next[i];
    end
  end

endmodule
